// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed memory: accepts one request at a time, RMW for sub-word stores.
// Latency: load/word store 2 cycles, sub-word store 3 cycles, fault 1 cycle; req_ready high only when idle.
module mem_access_unit #(
    parameter int MEM_WORDS = 51
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    localparam logic [29:0] WORDS_W = 30'(MEM_WORDS);

    state_t      state, state_next;
    logic        wr_q, sgn_q, fault_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q, merge_q;

    logic        req_fault;
    logic [4:0]  shift;
    logic [31:0] lane_shifted, load_ext, lane_mask, merged;
    logic [15:0] half;

    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'b11)                          req_fault = 1'b1;
        if (req_size == 2'b01 && req_addr[0])           req_fault = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_fault = 1'b1;
        if (req_addr[31:2] >= WORDS_W)                  req_fault = 1'b1;
    end

    // Lane extraction and merge both work off the latched address and the live read data.
    always_comb begin
        shift        = {addr_q[1:0], 3'b000};
        lane_shifted = mem_read_data >> shift;
        half         = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_ext = sgn_q ? {{24{lane_shifted[7]}}, lane_shifted[7:0]}
                                      : {24'b0, lane_shifted[7:0]};
            2'b01:   load_ext = sgn_q ? {{16{half[15]}}, half} : {16'b0, half};
            default: load_ext = mem_read_data;
        endcase
        lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        merged    = (mem_read_data & ~(lane_mask << shift)) | ((wdata_q & lane_mask) << shift);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_fault ? RESP : ACCESS;
            ACCESS:  state_next = (wr_q && size_q != 2'b10) ? MERGE : RESP;
            MERGE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            fault_q <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            merge_q <= 32'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                fault_q <= req_fault;
                rdata_q <= 32'b0;
            end
            if (state == ACCESS) begin
                if (!wr_q) rdata_q <= load_ext;
                merge_q <= merged;
            end
        end
    end

    // All memory-side outputs decode from registered state only.
    always_comb begin
        req_ready      = (state == IDLE);
        resp_valid     = (state == RESP);
        resp_rdata     = (state == RESP) ? rdata_q : 32'b0;
        resp_fault     = (state == RESP) ? fault_q : 1'b0;
        mem_we         = 1'b0;
        mem_address    = 32'b0;
        mem_write_data = 32'b0;
        if (state == ACCESS) begin
            mem_address = {addr_q[31:2], 2'b00};
            if (wr_q && size_q == 2'b10) begin
                mem_we         = 1'b1;
                mem_write_data = wdata_q;
            end
        end else if (state == MERGE) begin
            mem_address    = {addr_q[31:2], 2'b00};
            mem_we         = 1'b1;
            mem_write_data = merge_q;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with an attached async-read memory and a response scoreboard.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:63];
    logic [31:0] sb_rd[$];
    logic        sb_f[$];
    int          total = 0;
    int          fails = 0;

    mem_access_unit #(.MEM_WORDS(51)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_we(mem_we), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_address[7:2]] <= mem_write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] rd, input logic f);
        logic [31:0] erd;
        logic        ef;
        erd = 32'hxxxx_xxxx;
        ef  = 1'bx;
        if (sb_rd.size() > 0) begin
            erd = sb_rd.pop_front();
            ef  = sb_f.pop_front();
        end
        chk({tag, " rdata"}, rd, erd);
        chk({tag, " fault"}, {31'b0, f}, {31'b0, ef});
    endtask

    task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f,
                          input int exp_lat, input int exp_we, input logic [31:0] exp_wa);
        int          lat, we_n;
        logic [31:0] wa, got_rd;
        logic        got_f;
        lat = 0; we_n = 0; wa = 32'b0; got_rd = 32'hxxxx_xxxx; got_f = 1'bx;
        sb_rd.push_back(exp_rd);
        sb_f.push_back(exp_f);
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_n++;
                wa = mem_address;
            end
            if (resp_valid) begin
                lat = k; got_rd = resp_rdata; got_f = resp_fault;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        pop_chk(tag, got_rd, got_f);
        chk({tag, " we cycles"}, we_n, exp_we);
        if (exp_we > 0) chk({tag, " we addr"}, wa, exp_wa);
    endtask

    initial begin
        #12;
        chk("rst ready", {31'b0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst mem_address", mem_address, 32'd0);
        chk("rst rdata", resp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req("st_w10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h10);
        do_req("ld_w10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0);
        do_req("st_w20", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0, 2, 1, 32'h20);
        do_req("st_b22", 1, 2'b00, 0, 32'h22, 32'h000000AB, 32'h0, 0, 3, 1, 32'h20);
        chk("mem20 after rmw", mem[8], 32'h11AB3344);
        do_req("st_w24", 1, 2'b10, 0, 32'h24, 32'h80F0007F, 32'h0, 0, 2, 1, 32'h24);
        do_req("ld_bu24", 0, 2'b00, 0, 32'h24, 32'h0, 32'h0000007F, 0, 2, 0, 32'h0);
        do_req("ld_bs26", 0, 2'b00, 1, 32'h26, 32'h0, 32'hFFFFFFF0, 0, 2, 0, 32'h0);
        do_req("ld_hs26", 0, 2'b01, 1, 32'h26, 32'h0, 32'hFFFF80F0, 0, 2, 0, 32'h0);
        do_req("ld_hu26", 0, 2'b01, 0, 32'h26, 32'h0, 32'h000080F0, 0, 2, 0, 32'h0);
        do_req("st_h22", 1, 2'b01, 0, 32'h22, 32'h0000BEEF, 32'h0, 0, 3, 1, 32'h20);
        chk("mem20 after half", mem[8], 32'hBEEF3344);

        do_req("flt_h21", 1, 2'b01, 0, 32'h21, 32'h12345678, 32'h0, 1, 1, 0, 32'h0);
        do_req("flt_w22", 1, 2'b10, 0, 32'h22, 32'h12345678, 32'h0, 1, 1, 0, 32'h0);
        do_req("flt_wcc", 0, 2'b10, 0, 32'hCC, 32'h0, 32'h0, 1, 1, 0, 32'h0);
        do_req("flt_sz3", 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 1, 0, 32'h0);
        chk("mem20 after faults", mem[8], 32'hBEEF3344);
        do_req("ld_wc8", 0, 2'b10, 0, 32'hC8, 32'h0, 32'h0, 0, 2, 0, 32'h0);

        // Back-to-back loads with req_valid held high throughout.
        sb_rd.push_back(32'hDEADBEEF); sb_f.push_back(1'b0);
        sb_rd.push_back(32'h80F0007F); sb_f.push_back(1'b0);
        @(negedge clk);
        req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h10; req_valid = 1'b1;
        chk("hs ready0", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_addr = 32'h24;
        @(negedge clk);
        chk("hs ready access", {31'b0, req_ready}, 32'd0);
        chk("hs resp early", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        chk("hs ready resp", {31'b0, req_ready}, 32'd0);
        chk("hs resp1 valid", {31'b0, resp_valid}, 32'd1);
        pop_chk("hs resp1", resp_rdata, resp_fault);
        @(negedge clk);
        chk("hs ready idle", {31'b0, req_ready}, 32'd1);
        chk("hs resp gap", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("hs second accepted", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        chk("hs resp2 valid", {31'b0, resp_valid}, 32'd1);
        pop_chk("hs resp2", resp_rdata, resp_fault);
        @(negedge clk);
        chk("hs no dup", {31'b0, req_ready | resp_valid}, 32'd1);
        chk("hs resp after", {31'b0, resp_valid}, 32'd0);

        // Asynchronous reset while a byte store is in its read phase.
        do_req("st_w30", 1, 2'b10, 0, 32'h30, 32'h55667788, 32'h0, 0, 2, 1, 32'h30);
        @(negedge clk);
        req_write = 1; req_size = 2'b00; req_addr = 32'h30; req_wdata = 32'hCC; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 chk("rr in access", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rr mem_we", {31'b0, mem_we}, 32'd0);
        chk("rr ready", {31'b0, req_ready}, 32'd1);
        chk("rr resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rr resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rr resp_rdata", resp_rdata, 32'd0);
        chk("rr mem_address", mem_address, 32'd0);
        chk("rr mem_wdata", mem_write_data, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin
            int act;
            act = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (resp_valid || mem_we) act++;
            end
            chk("rr no activity", act, 32'd0);
        end
        chk("rr mem30", mem[12], 32'h55667788);
        do_req("ld_w30", 0, 2'b10, 0, 32'h30, 32'h0, 32'h55667788, 0, 2, 0, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the word-addressed data memory port (asynchronous read, write on clock edge when `we` is high). Accepts one byte/halfword/word request at a time from the pipeline MEM stage over a valid/ready handshake and drives `mem_we`/`mem_address`/`mem_write_data`. Loads come back sign- or zero-extended. Sub-word stores are done as read-modify-write. Misaligned and out-of-range accesses return a fault and never touch memory.

## Interface
- `MEM_WORDS`, default 51: number of 32-bit words in the attached memory. A word index `addr[31:2] >= MEM_WORDS` is out of range.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request (high only in IDLE).
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_signed` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified for sub-word sizes.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load result.
- `resp_fault` out 1: valid with `resp_valid`; request was rejected.
- `mem_we` out 1: memory write enable.
- `mem_address` out 32: word-aligned byte address `{addr[31:2],2'b00}`.
- `mem_write_data` out 32: memory write data.
- `mem_read_data` in 32: memory read data (combinational from `mem_address`).

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch write, size, signed, addr and wdata.
  - Faulting request → RESP.
  - Otherwise → ACCESS.
- **Fault conditions**
  - `req_size`=11.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `addr[31:2] >= MEM_WORDS`.
- **ACCESS**
  - Drive `mem_address`.
  - Load: capture the extracted, extended lane from `mem_read_data` → RESP.
  - Word store: `mem_we`=1, `mem_write_data`=wdata → RESP.
  - Sub-word store: `mem_we`=0; capture the merged word (old word with the target lane replaced by low wdata bits) → MERGE.
- **MERGE**
  - `mem_we`=1, same address, `mem_write_data`=merged word → RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle → IDLE.
  - `resp_rdata`: load result, or 0 for stores and faults.
  - `resp_fault`: 1 only for a faulted request.
- **Lanes (little-endian)**
  - Byte k = `addr[1:0]` occupies bits [8k+7:8k].
  - Halfword at `addr[1]`=h occupies bits [16h+15:16h].
  - Sign-extension replicates the lane MSB into the upper bits.
- **Idle outputs**
  - Outside ACCESS/MERGE: `mem_we`=0, `mem_address`=0, `mem_write_data`=0.
  - `mem_we` decodes from the state register only, never from inputs.
- `req_valid` while not in IDLE is ignored; the requester must hold it until accepted.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0, `mem_we`=0, `mem_address`=0, `mem_write_data`=0.
- **Cycle numbering:** accept at edge N.
  - ACCESS occupies cycle N..N+1.
  - Load / word store: `resp_valid` high in cycle N+1..N+2; next accept possible at edge N+3.
  - Sub-word store: MERGE in N+1..N+2, `resp_valid` in N+2..N+3; memory write lands at edge N+2.
  - Fault: `resp_valid` in N..N+1 relative to the acceptance edge, i.e. one cycle after accept; `mem_we` never asserted.
- **Reset mid-operation**
  - State returns to IDLE immediately and `mem_we` drops asynchronously.
  - A pending write is dropped (no partial merge written); no `resp_valid` is issued for it.
- **Load data:** `mem_read_data` is sampled at the edge ending ACCESS. The unit relies on asynchronous memory read; no extra wait state.

## Test plan
- **Word store then load:**
  - Store word 0xDEADBEEF @0x10, then load word @0x10.
  - Required: `mem_we` for one cycle with `mem_address`=0x10; load returns 0xDEADBEEF with `resp_fault`=0.
  - Latency: `resp_valid` two edges after each accept.
- **Byte store RMW:**
  - Word @0x20 = 0x11223344; store byte 0xAB @0x22.
  - Required: one read cycle with `mem_we`=0, then a write of 0x11AB3344; `resp_valid` three edges after accept.
- **Sub-word loads with extension** (word @0x24 = 0x80F0007F):
  - Load byte @0x24, unsigned → 0x0000007F.
  - Load byte @0x26, signed → 0xFFFFFFF0.
  - Load halfword @0x26, signed → 0xFFFF80F0.
  - Load halfword @0x26, unsigned → 0x000080F0.
- **Faults:** each of the following gets `resp_fault`=1, `resp_rdata`=0, `mem_we` never high, and memory unchanged.
  - Halfword @0x21.
  - Word @0x22.
  - Word @0xCC, which is word 51 and out of range.
  - Size 11.
- **Handshake:**
  - Hold `req_valid` continuously with two back-to-back word loads.
  - Required: `req_ready` low in ACCESS/RESP; second request accepted exactly at edge N+3; no duplicate accept.
- **Async reset mid-RMW:**
  - Assert `reset` during ACCESS of a byte store @0x30.
  - Required: `mem_we` stays 0, word @0x30 unchanged, all outputs at reset values, `req_ready`=1 before the next clock edge.
